ext_irq_ctrl: RTL and testbench

- Multi-source external interrupt controller between board inputs (push buttons, peripheral IRQ lines) and the CPU's single machine external interrupt input.
- Per source: synchronises and debounces the raw input, then latches rising edges as pending.
- Arbitrates pending sources by fixed priority and presents one interrupt line to the core.
- Runs a claim/complete handshake so only one source is in service at a time.

---
 rtl/ext_irq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ext_irq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: multi-source external interrupt controller.
// Each source is synchronised, optionally debounced, and rising-edge latched
// as pending. A fixed-priority arbiter (index 0 highest) feeds one interrupt
// line to the core, and a claim/complete handshake keeps one source in service.
// Build option: define EXT_IRQ_DEBOUNCE_EN to insert the DEB_CYCLES debounce
// filter; without it the synchronised level is used directly.
module ext_irq_ctrl #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               claim,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic               ext_irq,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  typedef enum logic {IDLE, SERVICE} state_e;

  // Reject parameter sets the ID encoding or the filter cannot support.
  if (NUM_SRC < 1 || NUM_SRC > 7 || (2 ** ID_W) <= NUM_SRC || DEB_CYCLES < 2) begin : g_param_chk
    $error("ext_irq_ctrl: illegal parameter set");
  end

  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  logic [NUM_SRC-1:0] stable;
  logic [NUM_SRC-1:0] stable_dly_q;
  logic [NUM_SRC-1:0] rise;

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef EXT_IRQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_SRC-1:0]            stable_q, stable_d;
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Level only follows the input after DEB_CYCLES consecutive mismatching cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync2_q;
`endif

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_dly_q <= '0;
    end else begin
      stable_dly_q <= stable;
    end
  end

  assign rise = stable & ~stable_dly_q;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               ext_irq_q, ext_irq_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic               has_win;

  assign req = pending_q & irq_en;

  // Fixed-priority arbiter: lowest requesting index wins.
  always_comb begin
    has_win = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !has_win) begin
        has_win   = 1'b1;
        win_idx   = ID_W'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  // Claim/complete FSM next state and registered-output next values.
  always_comb begin
    logic [NUM_SRC-1:0] pend_clr;
    state_d    = state_q;
    claim_id_d = claim_id_q;
    ext_irq_d  = 1'b0;
    pend_clr   = '0;
    case (state_q)
      IDLE: begin
        ext_irq_d = |req;
        if (claim) begin
          if (has_win) begin
            claim_id_d = win_idx + ID_W'(1);
            pend_clr   = win_oh;
            state_d    = SERVICE;
            ext_irq_d  = 1'b0;
          end else begin
            claim_id_d = '0;
          end
        end
      end
      SERVICE: begin
        if (complete && (complete_id == claim_id_q)) begin
          state_d = IDLE;
        end
        if (claim) begin
          claim_id_d = '0;
        end
      end
    endcase
    // A new enabled edge wins over the clear from a claim on the same source.
    pending_d = (pending_q & ~pend_clr) | (rise & irq_en);
    busy_d    = (state_d == SERVICE);
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      claim_id_q <= '0;
      pending_q  <= '0;
      ext_irq_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      claim_id_q <= claim_id_d;
      pending_q  <= pending_d;
      ext_irq_q  <= ext_irq_d;
      busy_q     <= busy_d;
    end
  end

  assign claim_id = claim_id_q;
  assign pending  = pending_q;
  assign ext_irq  = ext_irq_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Testbench for ext_irq_ctrl: directed scenarios plus random traffic, every
// cycle compared against a behavioural model of the controller's rules.
module tb_ext_irq_ctrl;

  localparam int NS  = 4;
  localparam int IW  = 3;
  localparam int DEB = 4;
`ifdef EXT_IRQ_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif
  // Edge (counted from the edge where irq_in is first sampled low) at which
  // the filtered level goes high for an input raised just after edge 0.
  localparam int LAT = DEB_ON ? 2 + DEB : 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] irq_in;
  logic [NS-1:0] irq_en;
  logic          claim;
  logic [IW-1:0] claim_id;
  logic          complete;
  logic [IW-1:0] complete_id;
  logic          ext_irq;
  logic [NS-1:0] pending;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  ext_irq_ctrl #(.NUM_SRC(NS), .ID_W(IW), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .irq_en      (irq_en),
    .claim       (claim),
    .claim_id    (claim_id),
    .complete    (complete),
    .complete_id (complete_id),
    .ext_irq     (ext_irq),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  bit [NS-1:0] m_s1, m_s2, m_lvl, m_lvl_d, m_pend;
  int          m_run [NS];
  bit          m_busy, m_irq;
  bit [IW-1:0] m_id;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_pend = '0;
    for (int i = 0; i < NS; i++) m_run[i] = 0;
    m_busy = 1'b0; m_irq = 1'b0; m_id = '0;
  endfunction

  // One clock edge of the controller, applied to the inputs seen at that edge.
  function automatic void model_edge();
    bit [NS-1:0] lvl_now, rise, elig, clr;
    int          win;
    bit          nbusy, nirq;
    bit [IW-1:0] nid;
    lvl_now = DEB_ON ? m_lvl : m_s2;
    rise    = lvl_now & ~m_lvl_d;
    elig    = m_pend & irq_en;
    win     = -1;
    for (int i = 0; i < NS; i++) if (elig[i] && win < 0) win = i;
    clr = '0; nbusy = m_busy; nid = m_id; nirq = 1'b0;
    if (!m_busy) begin
      nirq = (elig != 0);
      if (claim) begin
        if (win >= 0) begin
          nid = IW'(win + 1); clr[win] = 1'b1; nbusy = 1'b1; nirq = 1'b0;
        end else begin
          nid = '0;
        end
      end
    end else begin
      if (complete && complete_id == m_id) nbusy = 1'b0;
      if (claim) nid = '0;
    end
    m_pend = (m_pend & ~clr) | (rise & irq_en);
    for (int i = 0; i < NS; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_lvl[i] = m_s2[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_lvl_d = lvl_now;
    m_s2 = m_s1; m_s1 = irq_in;
    m_busy = nbusy; m_id = nid; m_irq = nirq;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge, update the model, compare every output.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pending", 8'(pending), 8'(m_pend));
    check("ext_irq", 8'(ext_irq), 8'(m_irq));
    check("busy", 8'(busy), 8'(m_busy));
    check("claim_id", 8'(claim_id), 8'(m_id));
  endtask

  task automatic do_claim();
    claim = 1'b1; tick(); claim = 1'b0;
  endtask

  task automatic do_complete(input logic [IW-1:0] id);
    complete = 1'b1; complete_id = id; tick(); complete = 1'b0; complete_id = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_claim_id"}, 8'(claim_id), 8'h0);
    check({tag, "_pending"}, 8'(pending), 8'h0);
    check({tag, "_busy"}, 8'(busy), 8'h0);
    check({tag, "_ext_irq"}, 8'(ext_irq), 8'h0);
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; irq_en = 4'hF; claim = 1'b0;
    complete = 1'b0; complete_id = '0;
    model_reset();
    #12;
    check_zero("rst");
    @(negedge clk); reset = 1'b0;

    // Latency from a held input to pending and ext_irq.
    tick();
    irq_in[0] = 1'b1;
    repeat (LAT) tick();
    check("lat_pend_early", 8'(pending), 8'h0);
    tick();
    check("lat_pend", 8'(pending), 8'h1);
    check("lat_irq_early", 8'(ext_irq), 8'h0);
    tick();
    check("lat_irq", 8'(ext_irq), 8'h1);

    do_claim();
    check("c0_id", 8'(claim_id), 8'h1);
    check("c0_busy", 8'(busy), 8'h1);
    do_complete(3'd1);
    check("c0_done", 8'(busy), 8'h0);
    irq_in = '0;
    repeat (LAT + 3) tick();

    // Bounce filtering: 2-cycle toggles, then a steady high.
    for (int c = 0; c < 20; c++) begin
      irq_in[0] = ((c / 2) % 2) == 0;
      tick();
`ifdef EXT_IRQ_DEBOUNCE_EN
      check("bounce_pend", 8'(pending), 8'h0);
`endif
    end
    irq_in[0] = 1'b1;
    repeat (LAT + 3) tick();
    check("bounce_one", 8'(pending), 8'h1);
    do_claim();
    check("bounce_id", 8'(claim_id), 8'h1);
    do_complete(3'd1);
    do_claim();
    check("bounce_once", 8'(claim_id), 8'h0);
    irq_in = '0;
    repeat (LAT + 3) tick();

    // Priority and handshake misuse.
    irq_in = 4'b0110;
    repeat (LAT + 3) tick();
    check("prio_pend", 8'(pending), 8'h6);
    check("prio_irq", 8'(ext_irq), 8'h1);
    do_claim();
    check("prio_id", 8'(claim_id), 8'h2);
    check("prio_pend2", 8'(pending), 8'h4);
    check("prio_busy", 8'(busy), 8'h1);
    check("prio_irq0", 8'(ext_irq), 8'h0);
    do_complete(3'd4);
    check("bad_cmpl_busy", 8'(busy), 8'h1);
    do_complete(3'd2);
    check("cmpl_busy", 8'(busy), 8'h0);
    check("cmpl_irq_same", 8'(ext_irq), 8'h0);
    tick();
    check("cmpl_irq_next", 8'(ext_irq), 8'h1);
    do_claim();
    check("prio_id2", 8'(claim_id), 8'h3);
    do_claim();
    check("svc_claim_id", 8'(claim_id), 8'h0);
    check("svc_claim_busy", 8'(busy), 8'h1);
    do_complete(m_id);
    check("svc_exit", 8'(busy), 8'h0);
    do_claim();
    check("empty_claim", 8'(claim_id), 8'h0);
    check("empty_busy", 8'(busy), 8'h0);
    irq_in = '0;
    repeat (LAT + 3) tick();

    // Masked rise is dropped, not remembered.
    irq_en = 4'b0111; irq_in[3] = 1'b1;
    repeat (LAT + 3) tick();
    check("mask_pend", 8'(pending), 8'h0);
    check("mask_irq", 8'(ext_irq), 8'h0);
    irq_en = 4'hF;
    tick();
    check("mask_forgot", 8'(pending), 8'h0);
    irq_in = '0;
    repeat (LAT + 3) tick();

    // Three rises on one source merge into a single pending bit.
    repeat (3) begin
      irq_in[1] = 1'b1; repeat (LAT + 1) tick();
      irq_in[1] = 1'b0; repeat (LAT + 1) tick();
    end
    check("merge_pend", 8'(pending), 8'h2);
    do_claim();
    check("merge_id", 8'(claim_id), 8'h2);
    do_complete(3'd2);
    do_claim();
    check("merge_none", 8'(claim_id), 8'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NS; b++)
        if ($urandom_range(9) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(39) == 0) irq_en = NS'($urandom);
      claim    = ($urandom_range(5) == 0);
      complete = ($urandom_range(4) == 0);
      complete_id = $urandom_range(1) ? m_id : IW'($urandom_range(7));
      tick();
    end
    claim = 1'b0; complete = 1'b0; complete_id = '0;

    // Clean restart, then asynchronous reset while in service.
    irq_in = '0; irq_en = 4'hF;
    reset = 1'b1; #2;
    model_reset();
    check_zero("rst2");
    #1; reset = 1'b0;
    irq_in = 4'b0001;
    repeat (LAT + 3) tick();
    do_claim();
    check("rs_id", 8'(claim_id), 8'h1);
    irq_in = 4'b1011;
    repeat (LAT + 3) tick();
    check("rs_pend", 8'(pending), 8'hA);
    check("rs_busy", 8'(busy), 8'h1);
    #2; reset = 1'b1; #1;
    check_zero("rs_async");
    model_reset();
    irq_in = '0;
    @(negedge clk); reset = 1'b0;
    tick();
    check("rs_idle_busy", 8'(busy), 8'h0);
    check("rs_idle_pend", 8'(pending), 8'h0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
